exec_alu_unit: RTL and testbench

- Execute stage of the KGP-RISC datapath, directly downstream of the register file.
- Consumes the two register read ports (operand A, operand B) plus a function code from decode.
- Produces a registered result with a one-cycle write-enable pulse that drives the register file write-data and write-enable inputs.
- Shifts are multi-cycle; all other ops are single-cycle; a start/busy/done handshake sequences them.

---
 rtl/kgp_exec_pkg.sv | 26 ++
 rtl/lsb_diff_encoder.sv | 21 ++
 rtl/exec_alu_unit.sv | 162 ++++++++++++++++
 tb/tb_exec_alu_unit.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/kgp_exec_pkg.sv
// Shared definitions for the KGP-RISC execute stage:
// default widths, function codes and the FSM encoding.
package kgp_exec_pkg;

    localparam int DATA_W_DEF  = 32;
    localparam int SHAMT_W_DEF = 5;

    localparam logic [3:0] FN_ADD  = 4'd0;
    localparam logic [3:0] FN_COMP = 4'd1;
    localparam logic [3:0] FN_AND  = 4'd2;
    localparam logic [3:0] FN_XOR  = 4'd3;
    localparam logic [3:0] FN_SHLL = 4'd4;
    localparam logic [3:0] FN_SHRL = 4'd5;
    localparam logic [3:0] FN_SHRA = 4'd6;
    localparam logic [3:0] FN_DIFF = 4'd7;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    function automatic logic is_shift(input logic [3:0] fn);
        return (fn == FN_SHLL) || (fn == FN_SHRL) || (fn == FN_SHRA);
    endfunction

endpackage

// File: rtl/lsb_diff_encoder.sv
// Lowest set-bit index of a vector, or DATA_W when the vector is zero.
// Fed with op_a ^ op_b it yields the first differing bit position.
module lsb_diff_encoder #(
    parameter int DATA_W = 32,
    parameter int IDX_W  = $clog2(DATA_W) + 1
) (
    input  logic [DATA_W-1:0] vec,
    output logic [IDX_W-1:0]  idx
);

    // Scan from the top so the lowest set bit is the last one written.
    always_comb begin
        idx = IDX_W'(DATA_W);
        for (int i = DATA_W - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/exec_alu_unit.sv
// KGP-RISC execute stage: single-cycle ALU plus iterative shifter.
// EXEC_FAST_SHIFT_EN selects a one-cycle barrel shifter instead.
module exec_alu_unit
    import kgp_exec_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int SHAMT_W = SHAMT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [3:0]        func,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              reg_write,
    output logic              zero,
    output logic              sign,
    output logic              carry
);

    localparam int IDX_W = $clog2(DATA_W) + 1;

    state_t              state;
    state_t              state_nxt;
    logic [DATA_W-1:0]   acc;
    logic [DATA_W-1:0]   acc_nxt;
    logic [DATA_W-1:0]   acc_step;
    logic [SHAMT_W-1:0]  cnt;
    logic [SHAMT_W-1:0]  cnt_nxt;
    logic [3:0]          fn;
    logic [3:0]          fn_nxt;
    logic [SHAMT_W-1:0]  shamt;
    logic [DATA_W-1:0]   alu_res;
    logic                alu_carry;
    logic [DATA_W-1:0]   result_nxt;
    logic                carry_nxt;
    logic                wr_nxt;
    logic                fire;
    logic                go_iter;
    logic [IDX_W-1:0]    diff_idx;

    assign shamt = op_b[SHAMT_W-1:0];
    assign busy  = (state == ST_SHIFT);

    lsb_diff_encoder #(
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_diff (
        .vec (op_a ^ op_b),
        .idx (diff_idx)
    );

`ifdef EXEC_FAST_SHIFT_EN
    assign go_iter = 1'b0;
`else
    assign go_iter = is_shift(func) && (shamt != '0);
`endif

    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        case (func)
            FN_ADD:  {alu_carry, alu_res} = {1'b0, op_a} + {1'b0, op_b};
            FN_COMP: alu_res = ~op_b + DATA_W'(1);
            FN_AND:  alu_res = op_a & op_b;
            FN_XOR:  alu_res = op_a ^ op_b;
`ifdef EXEC_FAST_SHIFT_EN
            FN_SHLL: alu_res = op_a << shamt;
            FN_SHRL: alu_res = op_a >> shamt;
            FN_SHRA: alu_res = DATA_W'($signed(op_a) >>> shamt);
`else
            // Only reached with a zero shift amount.
            FN_SHLL: alu_res = op_a;
            FN_SHRL: alu_res = op_a;
            FN_SHRA: alu_res = op_a;
`endif
            FN_DIFF: alu_res = DATA_W'(diff_idx);
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        case (fn)
            FN_SHLL: acc_step = {acc[DATA_W-2:0], 1'b0};
            FN_SHRL: acc_step = {1'b0, acc[DATA_W-1:1]};
            default: acc_step = {acc[DATA_W-1], acc[DATA_W-1:1]};
        endcase
    end

    always_comb begin
        state_nxt  = state;
        acc_nxt    = acc;
        cnt_nxt    = cnt;
        fn_nxt     = fn;
        fire       = 1'b0;
        result_nxt = alu_res;
        carry_nxt  = alu_carry;
        wr_nxt     = ~func[3];
        case (state)
            ST_IDLE: begin
                if (start && go_iter) begin
                    state_nxt = ST_SHIFT;
                    acc_nxt   = op_a;
                    cnt_nxt   = shamt;
                    fn_nxt    = func;
                end else if (start) begin
                    fire = 1'b1;
                end
            end
            ST_SHIFT: begin
                acc_nxt = acc_step;
                cnt_nxt = cnt - SHAMT_W'(1);
                if (cnt == SHAMT_W'(1)) begin
                    state_nxt  = ST_IDLE;
                    fire       = 1'b1;
                    result_nxt = acc_step;
                    carry_nxt  = 1'b0;
                    wr_nxt     = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= '0;
            cnt       <= '0;
            fn        <= FN_ADD;
            done      <= 1'b0;
            reg_write <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            sign      <= 1'b0;
            carry     <= 1'b0;
        end else begin
            acc       <= acc_nxt;
            cnt       <= cnt_nxt;
            fn        <= fn_nxt;
            done      <= fire;
            reg_write <= fire & wr_nxt;
            if (fire) begin
                result <= result_nxt;
                zero   <= (result_nxt == '0);
                sign   <= result_nxt[DATA_W-1];
                carry  <= carry_nxt;
            end
        end
    end

endmodule

// File: tb/tb_exec_alu_unit.sv
// Bench for exec_alu_unit: vector table plus shift/reset sequences,
// results checked through a scoreboard queue.
module tb_exec_alu_unit;
    import kgp_exec_pkg::*;

    logic        clk;
    logic        rst;
    logic        start;
    logic [3:0]  func;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        reg_write;
    logic        zero;
    logic        sign;
    logic        carry;

    exec_alu_unit #(.DATA_W(32), .SHAMT_W(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .func      (func),
        .op_a      (op_a),
        .op_b      (op_b),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .reg_write (reg_write),
        .zero      (zero),
        .sign      (sign),
        .carry     (carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic        z;
        logic        s;
        logic        c;
        logic        wr;
    } exp_t;

    typedef struct {
        logic [3:0]  fn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic        c;
        logic        wr;
    } vec_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] r, input logic c,
                        input logic wr);
        exp_t e;
        e.res = r;
        e.z   = (r == 32'h0);
        e.s   = r[31];
        e.c   = c;
        e.wr  = wr;
        sb.push_back(e);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (done) begin
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_done: got done=1 expected 0");
            end else begin
                e = sb.pop_front();
                chk("sb_result", result, e.res);
                chk("sb_zero", 32'(zero), 32'(e.z));
                chk("sb_sign", 32'(sign), 32'(e.s));
                chk("sb_carry", 32'(carry), 32'(e.c));
                chk("sb_reg_write", 32'(reg_write), 32'(e.wr));
            end
        end else if (reg_write) begin
            n_checks++;
            $display("FAIL stray_reg_write: got 1 expected 0");
        end
    end

    task automatic run_op(input string nm, input logic [3:0] f,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] r, input int k,
                          input bit inject);
        int lat;
        int nb;
        func  = f;
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        push(r, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        start = 1'b0;
        op_a  = $urandom;
        op_b  = $urandom;
        lat   = 1;
        nb    = 0;
        while (!done && lat < 64) begin
            if (busy) nb++;
            if (inject && lat == 2) begin
                start = 1'b1;
                func  = FN_ADD;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        start = 1'b0;
        chk({nm, "_latency"}, 32'(lat), 32'(k + 1));
        chk({nm, "_busy_cycles"}, 32'(nb), 32'(k));
    endtask

    vec_t vecs[13];

    initial begin
        vecs[0]  = '{FN_ADD,  32'd5,         32'd15,        32'd20,        1'b0, 1'b1};
        vecs[1]  = '{FN_ADD,  32'hFFFFFFFF,  32'h1,         32'h0,         1'b1, 1'b1};
        vecs[2]  = '{FN_COMP, 32'h0,         32'd5,         32'hFFFFFFFB,  1'b0, 1'b1};
        vecs[3]  = '{FN_AND,  32'hF0F0F0F0,  32'hFF00FF00,  32'hF000F000,  1'b0, 1'b1};
        vecs[4]  = '{FN_XOR,  32'h12345678,  32'h12345678,  32'h0,         1'b0, 1'b1};
        vecs[5]  = '{FN_DIFF, 32'h5,         32'h7,         32'd1,         1'b0, 1'b1};
        vecs[6]  = '{FN_DIFF, 32'hA,         32'hA,         32'd32,        1'b0, 1'b1};
        vecs[7]  = '{FN_DIFF, 32'h0,         32'h80000000,  32'd31,        1'b0, 1'b1};
        vecs[8]  = '{4'd12,   32'h1,         32'h2,         32'h0,         1'b0, 1'b0};
        vecs[9]  = '{FN_SHLL, 32'hABCD,      32'h0,         32'hABCD,      1'b0, 1'b1};
        vecs[10] = '{FN_SHRL, 32'h80000000,  32'h20,        32'h80000000,  1'b0, 1'b1};
        vecs[11] = '{FN_ADD,  32'h7FFFFFFF,  32'h1,         32'h80000000,  1'b0, 1'b1};
        vecs[12] = '{4'd15,   32'hFFFF,      32'hFFFF,      32'h0,         1'b0, 1'b0};

        rst   = 1'b1;
        start = 1'b0;
        func  = FN_ADD;
        op_a  = '0;
        op_b  = '0;
        #1;
        chk("rst_result", result, 32'h0);
        chk("rst_flags", {28'h0, busy, done, reg_write, zero | sign | carry},
            32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Back-to-back single-cycle ops: done every cycle, never busy.
        for (int i = 0; i < 13; i++) begin
            func  = vecs[i].fn;
            op_a  = vecs[i].a;
            op_b  = vecs[i].b;
            start = 1'b1;
            push(vecs[i].r, vecs[i].c, vecs[i].wr);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_done", i), 32'(done), 32'h1);
            chk($sformatf("vec%0d_busy", i), 32'(busy), 32'h0);
        end
        start = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_done", 32'(done), 32'h0);

        run_op("shra4", FN_SHRA, 32'h80000000, 32'd4, 32'hF8000000, 4, 1'b1);
        run_op("shll0", FN_SHLL, 32'h1234, 32'd0, 32'h1234, 0, 1'b0);
        run_op("shrl31", FN_SHRL, 32'hF0, 32'd31, 32'h0, 31, 1'b0);
        run_op("shrl1", FN_SHRL, 32'h80000001, 32'd1, 32'h40000000, 1, 1'b1);
        run_op("shll31", FN_SHLL, 32'h1, 32'd31, 32'h80000000, 31, 1'b0);

        // Abandon a shift with an asynchronous reset in its third cycle.
        func  = FN_SHRL;
        op_a  = 32'hFFFF0000;
        op_b  = 32'd10;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("midrst_result", result, 32'h0);
        chk("midrst_busy", 32'(busy), 32'h0);
        chk("midrst_outs", {28'h0, done, reg_write, zero, sign | carry},
            32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        chk("post_rst_busy", 32'(busy), 32'h0);

        run_op("add_after_rst", FN_ADD, 32'd2, 32'd3, 32'd5, 0, 1'b0);

        for (int i = 0; i < 5 && sb.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        chk("sb_drained", 32'(sb.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
